// File: rtl/sd_adc_decimator.sv
// First-order sigma-delta front end with a 3rd-order CIC decimator (R=64).
// Produces a signed 16-bit PCM sample with a one-cycle valid strobe.
module sd_adc_decimator #(
    parameter int unsigned WARMUP = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               d_in,
    output logic               q_fb,
    output logic signed [15:0] pcm,
    output logic               pcm_valid
);

    localparam int unsigned      CW       = 19;
    localparam logic [2:0]       WARM_MAX = 3'(WARMUP);
    localparam logic signed [19:0] MIDPOINT = 20'sd131072;

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          q_fb_q, q_fb_d;
    logic [CW-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
    logic [CW-1:0] z1_q, z1_d, z2_q, z2_d, z3_q, z3_d;
    logic [CW-1:0] comb_q, comb_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [2:0]    warm_q, warm_d;
    logic          pend_q, pend_d;
    logic signed [15:0] pcm_q, pcm_d;
    logic          valid_q, valid_d;

    logic          tick;
    logic [CW-1:0] y1, y2, y3;
    logic signed [19:0] diff, shr;
    logic signed [15:0] pcm_sat;

    // Comb stage and PCM conversion are pure datapath from the registered state.
    always_comb begin
        tick = (cnt_q == 6'd63);
        y1   = i3_q - z1_q;
        y2   = y1 - z2_q;
        y3   = y2 - z3_q;
        diff = $signed({1'b0, comb_q}) - MIDPOINT;
        shr  = diff >>> 2;
        if (shr > 20'sd32767) begin
            pcm_sat = 16'sd32767;
        end else if (shr < -20'sd32768) begin
            pcm_sat = -16'sd32768;
        end else begin
            pcm_sat = shr[15:0];
        end
    end

    always_comb begin
        // NOTE: every _d gets a hold/default value first so no path leaves it unassigned (no latches).
        s1_d    = d_in;
        s2_d    = s1_q;
        q_fb_d  = q_fb_q;
        i1_d    = i1_q;
        i2_d    = i2_q;
        i3_d    = i3_q;
        z1_d    = z1_q;
        z2_d    = z2_q;
        z3_d    = z3_q;
        comb_d  = comb_q;
        cnt_d   = cnt_q;
        warm_d  = warm_q;
        pend_d  = 1'b0;
        pcm_d   = pcm_q;
        valid_d = 1'b0;

        if (!enable) begin
            // Idle: square-wave feedback parks the external integrator at midpoint.
            q_fb_d = ~q_fb_q;
            i1_d   = '0;
            i2_d   = '0;
            i3_d   = '0;
            z1_d   = '0;
            z2_d   = '0;
            z3_d   = '0;
            comb_d = '0;
            cnt_d  = '0;
            warm_d = '0;
            pcm_d  = '0;
        end else begin
            q_fb_d = s2_q;
            i1_d   = i1_q + {{(CW-1){1'b0}}, s2_q};
            i2_d   = i2_q + i1_q;
            i3_d   = i3_q + i2_q;
            cnt_d  = cnt_q + 6'd1;

            valid_d = pend_q;
            if (pend_q) begin
                pcm_d = pcm_sat;
            end

            if (tick) begin
                comb_d = y3;
                z1_d   = i3_q;
                z2_d   = y1;
                z3_d   = y2;
                pend_d = (warm_q == WARM_MAX);
                if (warm_q != WARM_MAX) begin
                    warm_d = warm_q + 3'd1;
                end
            end
        end
    end

    // NOTE: state is updated only here, with non-blocking assignments, so all registers see pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            q_fb_q  <= 1'b0;
            i1_q    <= '0;
            i2_q    <= '0;
            i3_q    <= '0;
            z1_q    <= '0;
            z2_q    <= '0;
            z3_q    <= '0;
            comb_q  <= '0;
            cnt_q   <= '0;
            warm_q  <= '0;
            pend_q  <= 1'b0;
            pcm_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            q_fb_q  <= q_fb_d;
            i1_q    <= i1_d;
            i2_q    <= i2_d;
            i3_q    <= i3_d;
            z1_q    <= z1_d;
            z2_q    <= z2_d;
            z3_q    <= z3_d;
            comb_q  <= comb_d;
            cnt_q   <= cnt_d;
            warm_q  <= warm_d;
            pend_q  <= pend_d;
            pcm_q   <= pcm_d;
            valid_q <= valid_d;
        end
    end

    assign q_fb      = q_fb_q;
    assign pcm       = pcm_q;
    assign pcm_valid = valid_q;

endmodule

// File: tb/tb_sd_adc_decimator.sv
// Self-checking bench: fixed-pattern vector table, randomized run against a
// boxcar^3 FIR reference model, and hand sequences for enable/reset corners.
module tb_sd_adc_decimator;

    localparam int WARMUP       = 4;
    localparam int FIRST_STROBE = (WARMUP + 1) * 64 + 1;
    localparam int KLEN         = 190;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    logic enable  = 1'b0;
    logic d_in    = 1'b0;
    logic q_fb;
    logic signed [15:0] pcm;
    logic pcm_valid;

    sd_adc_decimator #(.WARMUP(WARMUP)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .d_in      (d_in),
        .q_fb      (q_fb),
        .pcm       (pcm),
        .pcm_valid (pcm_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: CIC^3/64 seen as a length-190 FIR (boxcar64 convolved
    // three times) applied to the sample history, read out every 64 samples.
    int h[KLEN];
    int xs[$];
    bit dl0, dl1;
    bit m_q;
    int m_pcm;
    bit m_valid;
    int m_ticks;
    bit m_pend;
    int m_pend_val;

    function automatic void build_kernel();
        int b2[127];
        for (int j = 0; j < 127; j++) b2[j] = 0;
        for (int a = 0; a < 64; a++)
            for (int b = 0; b < 64; b++) b2[a+b]++;
        for (int j = 0; j < KLEN; j++) begin
            h[j] = 0;
            for (int c = 0; c < 64; c++)
                if (j - c >= 0 && j - c < 127) h[j] += b2[j-c];
        end
    endfunction

    function automatic int cic_out(input int k);
        longint acc  = 0;
        int     base = 64 * k - 4;
        for (int j = 0; j < KLEN; j++)
            if (base - j >= 0) acc += longint'(h[j]) * xs[base-j];
        return int'(acc);
    endfunction

    function automatic int to_pcm(input int c);
        int v = (c - 131072) >>> 2;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    function automatic void model_clear(input bit full);
        xs.delete();
        m_ticks = 0;
        m_pend  = 1'b0;
        m_pcm   = 0;
        m_valid = 1'b0;
        if (full) begin
            dl0 = 1'b0;
            dl1 = 1'b0;
            m_q = 1'b0;
        end
    endfunction

    function automatic void model_step();
        bit x = dl1;
        dl1 = dl0;
        dl0 = d_in;
        if (!enable) begin
            m_q = !m_q;
            model_clear(1'b0);
        end else begin
            m_q     = x;
            m_valid = m_pend;
            if (m_pend) m_pcm = m_pend_val;
            m_pend = 1'b0;
            xs.push_back(int'(x));
            if (xs.size() % 64 == 0) begin
                if (m_ticks >= WARMUP) begin
                    m_pend     = 1'b1;
                    m_pend_val = to_pcm(cic_out(xs.size() / 64));
                end
                m_ticks++;
            end
        end
    endfunction

    initial begin
        model_clear(1'b1);
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_clear(1'b1);
            else model_step();
        end
    end

    bit mon_en = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("mdl_q_fb", q_fb, m_q);
                check("mdl_pcm", pcm, m_pcm);
                check("mdl_valid", pcm_valid, m_valid);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        string name;
        int    mode;       // 0: const 0, 1: const 1, 2: toggle each clk
        int    exp_pcm;
        int    exp_first;
        int    exp_count;
    } vec_t;

    vec_t vecs[3];

    function automatic logic pat_bit(input int mode, input int e);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            default: return 1'(e % 2);
        endcase
    endfunction

    task automatic start_run();
        @(negedge clk);
        reset_n = 1'b0;
        enable  = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run_edges(input int n);
        repeat (n) begin
            @(negedge clk);
            d_in = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_first_strobe(input string name);
        int e = 0;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            d_in = 1'($urandom_range(0, 1));
            if (pcm_valid) begin
                e = c;
                break;
            end
        end
        check(name, e, FIRST_STROBE);
    endtask

    task automatic run_vec(input vec_t v);
        int first   = 0;
        int last    = 0;
        int nstrobe = 0;
        bit early   = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        enable  = 1'b1;
        d_in    = pat_bit(v.mode, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int e = 1; e <= 7 * 64 + 8; e++) begin
            @(negedge clk);
            d_in = pat_bit(v.mode, e);
            if (pcm_valid) begin
                nstrobe++;
                if (first == 0) begin
                    first = e;
                    check({v.name, "_first_edge"}, e, v.exp_first);
                end else begin
                    check({v.name, "_period"}, e - last, 64);
                end
                check({v.name, "_pcm"}, pcm, v.exp_pcm);
                last = e;
            end else if (first == 0 && pcm != 0) begin
                early = 1'b1;
            end
        end
        check({v.name, "_pcm_before_first"}, early, 0);
        check({v.name, "_strobe_count"}, nstrobe, v.exp_count);
    endtask

    initial begin
        bit prev;
        build_kernel();
        vecs[0] = '{"ones",   1,  32767, FIRST_STROBE, 3};
        vecs[1] = '{"zeros",  0, -32768, FIRST_STROBE, 3};
        vecs[2] = '{"toggle", 2,      0, FIRST_STROBE, 3};

        #1 reset_n = 1'b0;
        #1;
        check("reset_q_fb", q_fb, 0);
        check("reset_pcm", pcm, 0);
        check("reset_valid", pcm_valid, 0);
        mon_en = 1'b1;

        for (int i = 0; i < 3; i++) run_vec(vecs[i]);

        // Randomized density per window with rare enable drops.
        start_run();
        for (int w = 0; w < 24; w++) begin
            int unsigned dens;
            dens = $urandom_range(0, 100);
            for (int c = 0; c < 64; c++) begin
                @(negedge clk);
                d_in   = ($urandom_range(0, 99) < dens);
                enable = ($urandom_range(0, 999) != 0);
            end
        end
        enable = 1'b1;

        // Enable dropped for 10 cycles mid-window, then a full warmup again.
        start_run();
        run_edges(400);
        prev   = q_fb;
        enable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_q_fb_toggle", q_fb, !prev);
            check("idle_pcm", pcm, 0);
            check("idle_valid", pcm_valid, 0);
            prev = q_fb;
        end
        enable = 1'b1;
        wait_first_strobe("rewarm_first_edge");

        // Enable falls between tick and strobe: that strobe never appears.
        start_run();
        run_edges(FIRST_STROBE);
        check("cw_strobe_present", pcm_valid, 1);
        run_edges(64 * (WARMUP + 2) - FIRST_STROBE);
        enable = 1'b0;
        @(negedge clk);
        check("cw_valid_suppressed", pcm_valid, 0);
        check("cw_pcm_cleared", pcm, 0);
        enable = 1'b1;
        wait_first_strobe("cw_rewarm_first_edge");

        // Asynchronous reset pulse between edges mid-conversion.
        start_run();
        run_edges(350);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("areset_pcm", pcm, 0);
        check("areset_valid", pcm_valid, 0);
        check("areset_q_fb", q_fb, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        wait_first_strobe("areset_first_edge");

        run_edges(8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
